// File: rtl/qbert_pkg.sv
// Shared types and helpers for the Q*bert board controller: FSM states,
// hop directions, pyramid tile indexing and the lives seven-segment decode.
package qbert_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOP,
    ST_FALL,
    ST_LOST,
    ST_WON
  } state_t;

  typedef enum logic [1:0] {
    DIR_UL,
    DIR_UR,
    DIR_DL,
    DIR_DR
  } dir_t;

  localparam int POS_W = 4;

  // Row r of the pyramid starts at tile r*(r+1)/2.
  function automatic int tile_idx(input int r, input int c);
    return r * (r + 1) / 2 + c;
  endfunction

  // Active-low segments, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7_n(input logic [2:0] d);
    logic [6:0] s;
    s = 7'b1111111;
    case (d)
      3'd0: s = 7'b1000000;
      3'd1: s = 7'b1111001;
      3'd2: s = 7'b0100100;
      3'd3: s = 7'b0110000;
      3'd4: s = 7'b0011001;
      3'd5: s = 7'b0010010;
      3'd6: s = 7'b0000010;
      3'd7: s = 7'b1111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/qbert_btn_edge.sv
// Button conditioner: 2-FF synchroniser followed by a rising-edge detector that
// stays disarmed until the button has been seen low after reset.
module qbert_btn_edge (
  input  logic clk_25,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync1_reg, sync2_reg, prev_reg;
  logic valid1_reg, valid2_reg, armed_reg;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      prev_reg   <= 1'b0;
      valid1_reg <= 1'b0;
      valid2_reg <= 1'b0;
      armed_reg  <= 1'b0;
    end else begin
      sync1_reg  <= btn;
      sync2_reg  <= sync1_reg;
      prev_reg   <= sync2_reg;
      valid1_reg <= 1'b1;
      valid2_reg <= valid1_reg;
      // A button held across reset release never looks like a fresh press.
      if (valid2_reg && !sync2_reg)
        armed_reg <= 1'b1;
    end
  end

  assign rise = armed_reg & sync2_reg & ~prev_reg;

endmodule

// File: rtl/qbert_board_ctrl.sv
// Q*bert pyramid board controller: hop/fall FSM, tile colouring, lives and win/lose.
// Build option: define QBERT_REVERT_EN to make completed tiles wrap back to 0.
module qbert_board_ctrl
  import qbert_pkg::*;
#(
  parameter int ROWS        = 6,
  parameter int COLOR_STEPS = 1,
  parameter int LIVES_INIT  = 3,
  parameter int HOP_FRAMES  = 8,
  localparam int NTILES     = ROWS * (ROWS + 1) / 2
) (
  input  logic                clk_25,
  input  logic                rst_n,
  input  logic                frame_tick,
  input  logic                button1,
  input  logic                button2,
  input  logic                button3,
  input  logic                button4,
  output logic [3:0]          pos_row,
  output logic [3:0]          pos_col,
  output logic                hopping,
  output logic [2*NTILES-1:0] tile_lvl,
  output logic [2:0]          lives,
  output logic                lost,
  output logic                ganar,
  output logic [6:0]          led
);

  localparam logic [1:0]        STEPS     = 2'(COLOR_STEPS);
  localparam logic [7:0]        LAST_TICK = 8'(HOP_FRAMES - 1);
  localparam logic signed [5:0] ROWS_S    = 6'(ROWS);

  state_t             state_reg, state_next;
  logic [POS_W-1:0]   row_reg, row_next, col_reg, col_next;
  logic [POS_W-1:0]   tgt_row_reg, tgt_row_next, tgt_col_reg, tgt_col_next;
  logic [7:0]         tick_reg, tick_next;
  logic [2:0]         lives_reg, lives_next;
  logic               win_chk_reg, win_chk_next;
  logic               land_en;
  logic [7:0]         land_idx;
  logic [NTILES-1:0]  done_vec;
  logic               all_done;

  logic [3:0]         btn_vec, rise;
  dir_t               dir;
  logic               any_rise, in_range;
  logic signed [5:0]  tr, tc;

  assign btn_vec = {button4, button3, button2, button1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      qbert_btn_edge u_btn (
        .clk_25 (clk_25),
        .rst_n  (rst_n),
        .btn    (btn_vec[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  // Lowest button number wins when several edges land together.
  always_comb begin
    dir      = DIR_UL;
    any_rise = |rise;
    if (rise[0])      dir = DIR_UL;
    else if (rise[1]) dir = DIR_UR;
    else if (rise[2]) dir = DIR_DL;
    else if (rise[3]) dir = DIR_DR;

    tr = $signed({2'b00, row_reg});
    tc = $signed({2'b00, col_reg});
    case (dir)
      DIR_UL: begin tr = tr - 6'sd1; tc = tc - 6'sd1; end
      DIR_UR: begin tr = tr - 6'sd1; end
      DIR_DL: begin tr = tr + 6'sd1; end
      DIR_DR: begin tr = tr + 6'sd1; tc = tc + 6'sd1; end
      default: ;
    endcase
    in_range = (tr >= 6'sd0) && (tr < ROWS_S) && (tc >= 6'sd0) && (tc <= tr);
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      row_reg     <= '0;
      col_reg     <= '0;
      tgt_row_reg <= '0;
      tgt_col_reg <= '0;
      tick_reg    <= '0;
      lives_reg   <= 3'(LIVES_INIT);
      win_chk_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      row_reg     <= row_next;
      col_reg     <= col_next;
      tgt_row_reg <= tgt_row_next;
      tgt_col_reg <= tgt_col_next;
      tick_reg    <= tick_next;
      lives_reg   <= lives_next;
      win_chk_reg <= win_chk_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    row_next     = row_reg;
    col_next     = col_reg;
    tgt_row_next = tgt_row_reg;
    tgt_col_next = tgt_col_reg;
    tick_next    = tick_reg;
    lives_next   = lives_reg;
    win_chk_next = 1'b0;
    land_en      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (win_chk_reg && all_done) begin
          state_next = ST_WON;
        end else if (any_rise) begin
          tick_next    = '0;
          tgt_row_next = tr[3:0];
          tgt_col_next = tc[3:0];
          if (in_range) begin
            state_next = ST_HOP;
          end else begin
            state_next = ST_FALL;
            lives_next = lives_reg - 3'd1;
          end
        end
      end
      ST_HOP: begin
        if (frame_tick) begin
          if (tick_reg == LAST_TICK) begin
            row_next     = tgt_row_reg;
            col_next     = tgt_col_reg;
            land_en      = 1'b1;
            win_chk_next = 1'b1;
            state_next   = ST_IDLE;
          end else begin
            tick_next = tick_reg + 8'd1;
          end
        end
      end
      ST_FALL: begin
        if (frame_tick) begin
          if (tick_reg == LAST_TICK) begin
            if (lives_reg == 3'd0) begin
              state_next = ST_LOST;
            end else begin
              row_next   = '0;
              col_next   = '0;
              state_next = ST_IDLE;
            end
          end else begin
            tick_next = tick_reg + 8'd1;
          end
        end
      end
      ST_LOST, ST_WON: ;
      default: state_next = ST_IDLE;
    endcase
  end

  assign land_idx = 8'(tile_idx(int'(tgt_row_reg), int'(tgt_col_reg)));

  generate
    for (gi = 0; gi < NTILES; gi++) begin : g_tile
      logic [1:0] lvl_reg;
      always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
          lvl_reg <= '0;
        end else if (land_en && (land_idx == 8'(gi))) begin
`ifdef QBERT_REVERT_EN
          lvl_reg <= (lvl_reg == STEPS) ? 2'd0 : lvl_reg + 2'd1;
`else
          if (lvl_reg != STEPS)
            lvl_reg <= lvl_reg + 2'd1;
`endif
        end
      end
      assign tile_lvl[2*gi +: 2] = lvl_reg;
      assign done_vec[gi]        = (lvl_reg == STEPS);
    end
  endgenerate

  assign all_done = &done_vec;

  assign pos_row = row_reg;
  assign pos_col = col_reg;
  assign hopping = (state_reg == ST_HOP) || (state_reg == ST_FALL);
  assign lives   = lives_reg;
  assign lost    = (state_reg == ST_LOST);
  assign ganar   = (state_reg == ST_WON);
  assign led     = seg7_n(lives_reg);

endmodule

// File: tb/tb_qbert_board_ctrl.sv
// Self-checking bench for qbert_board_ctrl: directed scenarios on a default and a
// two-row instance, plus random moves against a board model (honours QBERT_REVERT_EN).
module tb_qbert_board_ctrl;

  localparam int NT_A = 21;
  localparam int NT_B = 3;
  localparam int HF   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic [3:0] btn_a = '0, btn_b = '0;

  logic [3:0] row_a, col_a, row_b, col_b;
  logic hop_a, hop_b, lost_a, lost_b, ganar_a, ganar_b;
  logic [2*NT_A-1:0] lvl_a;
  logic [2*NT_B-1:0] lvl_b;
  logic [2:0] lives_a, lives_b;
  logic [6:0] led_a, led_b;

  int errors = 0;
  int checks = 0;

  int m_row, m_col, m_lives;
  int m_lvl[NT_A];
  bit m_lost, m_won;

  always #20 clk = ~clk;

  qbert_board_ctrl dut_a (
    .clk_25(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .button1(btn_a[0]), .button2(btn_a[1]), .button3(btn_a[2]), .button4(btn_a[3]),
    .pos_row(row_a), .pos_col(col_a), .hopping(hop_a), .tile_lvl(lvl_a),
    .lives(lives_a), .lost(lost_a), .ganar(ganar_a), .led(led_a)
  );

  qbert_board_ctrl #(.ROWS(2)) dut_b (
    .clk_25(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .button1(btn_b[0]), .button2(btn_b[1]), .button3(btn_b[2]), .button4(btn_b[3]),
    .pos_row(row_b), .pos_col(col_b), .hopping(hop_b), .tile_lvl(lvl_b),
    .lives(lives_b), .lost(lost_b), .ganar(ganar_b), .led(led_b)
  );

  // Expected led from the lit segments of each digit written in a..g order.
  function automatic logic [6:0] seg_exp(input int d);
    logic [6:0] lit;
    logic [6:0] r;
    case (d)
      0: lit = 7'b1111110;
      1: lit = 7'b0110000;
      2: lit = 7'b1101101;
      3: lit = 7'b1111001;
      4: lit = 7'b0110011;
      5: lit = 7'b1011011;
      6: lit = 7'b1011111;
      default: lit = 7'b1110000;
    endcase
    for (int i = 0; i < 7; i++) r[i] = ~lit[6-i];
    return r;
  endfunction

  function automatic int first_btn(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_row = 0; m_col = 0; m_lives = 3; m_lost = 0; m_won = 0;
    foreach (m_lvl[i]) m_lvl[i] = 0;
  endtask

  task automatic model_move(input int b);
    int tr, tc, idx;
    bit all;
    if (m_lost || m_won) return;
    tr = m_row; tc = m_col;
    case (b)
      1: begin tr = m_row - 1; tc = m_col - 1; end
      2: begin tr = m_row - 1; end
      3: begin tr = m_row + 1; end
      default: begin tr = m_row + 1; tc = m_col + 1; end
    endcase
    if (tr >= 0 && tr < 6 && tc >= 0 && tc <= tr) begin
      m_row = tr; m_col = tc;
      idx = tr * (tr + 1) / 2 + tc;
`ifdef QBERT_REVERT_EN
      m_lvl[idx] = (m_lvl[idx] == 1) ? 0 : m_lvl[idx] + 1;
`else
      if (m_lvl[idx] < 1) m_lvl[idx] = m_lvl[idx] + 1;
`endif
      all = 1;
      foreach (m_lvl[i]) if (m_lvl[i] != 1) all = 0;
      m_won = all;
    end else begin
      m_lives = m_lives - 1;
      if (m_lives == 0) m_lost = 1;
      else begin m_row = 0; m_col = 0; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
  endtask

  task automatic press(input bit on_b, input logic [3:0] mask);
    @(negedge clk);
    if (on_b) btn_b = mask; else btn_a = mask;
    repeat (4) @(negedge clk);
    btn_a = '0; btn_b = '0;
  endtask

  task automatic ticks(input int n, input int max_gap);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({row_a, col_a} !== 8'h00) begin errors++; $display("FAIL reset_pos got %h want 00", {row_a, col_a}); end
    checks++; if (lvl_a !== '0) begin errors++; $display("FAIL reset_tiles got %h want 0", lvl_a); end
    checks++; if (lives_a !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives_a); end
    checks++; if ({hop_a, lost_a, ganar_a} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {hop_a, lost_a, ganar_a}); end
    checks++; if (led_a !== seg_exp(3)) begin errors++; $display("FAIL reset_led got %b want %b", led_a, seg_exp(3)); end
    checks++; if ({row_b, col_b, lvl_b, lives_b} !== {8'h00, 6'd0, 3'd3}) begin errors++; $display("FAIL reset_b got %h", {row_b, col_b, lvl_b, lives_b}); end
  endtask

  task automatic test_hop();
    press(1'b0, 4'b1000);
    checks++; if (hop_a !== 1'b1) begin errors++; $display("FAIL hop_start got %b want 1", hop_a); end
    ticks(HF, 0);
    checks++; if ({row_a, col_a} !== 8'h11) begin errors++; $display("FAIL hop_pos got %h want 11", {row_a, col_a}); end
    checks++; if (lvl_a !== (42'd1 << 4)) begin errors++; $display("FAIL hop_tiles got %h want %h", lvl_a, 42'd1 << 4); end
    checks++; if (hop_a !== 1'b0) begin errors++; $display("FAIL hop_end got %b want 0", hop_a); end
  endtask

  task automatic test_fall();
    do_reset();
    press(1'b0, 4'b0001);
    checks++; if ({hop_a, lives_a} !== {1'b1, 3'd2}) begin errors++; $display("FAIL fall_entry got hop=%b lives=%0d want 1/2", hop_a, lives_a); end
    ticks(HF, 0);
    checks++; if ({row_a, col_a, hop_a} !== {8'h00, 1'b0}) begin errors++; $display("FAIL fall_respawn got %h", {row_a, col_a, hop_a}); end
    checks++; if (led_a !== seg_exp(2)) begin errors++; $display("FAIL fall_led got %b want %b", led_a, seg_exp(2)); end
  endtask

  task automatic test_lost();
    repeat (2) begin press(1'b0, 4'b0001); ticks(HF, 0); end
    @(negedge clk);
    checks++; if ({lost_a, ganar_a, lives_a} !== {2'b10, 3'd0}) begin errors++; $display("FAIL lost_flag got %b want 10000", {lost_a, ganar_a, lives_a}); end
    checks++; if (led_a !== seg_exp(0)) begin errors++; $display("FAIL lost_led got %b want %b", led_a, seg_exp(0)); end
    press(1'b0, 4'b1000);
    ticks(HF, 0);
    press(1'b0, 4'b0100);
    checks++; if ({row_a, col_a, hop_a, lost_a, lives_a} !== {8'h00, 2'b01, 3'd0}) begin errors++; $display("FAIL lost_frozen got %h", {row_a, col_a, hop_a, lost_a, lives_a}); end
    checks++; if (lvl_a !== '0) begin errors++; $display("FAIL lost_tiles got %h want 0", lvl_a); end
  endtask

  task automatic test_priority();
    do_reset();
    press(1'b0, 4'b1000);
    ticks(HF, 0);
    press(1'b0, 4'b1001);
    press(1'b0, 4'b0100);
    ticks(HF, 0);
    checks++; if ({row_a, col_a} !== 8'h00) begin errors++; $display("FAIL prio_pos got %h want 00", {row_a, col_a}); end
    repeat (10) @(negedge clk);
    checks++; if ({hop_a, row_a, col_a} !== 9'h000) begin errors++; $display("FAIL prio_no_queue got %h want 000", {hop_a, row_a, col_a}); end
    checks++; if (lvl_a[1:0] !== 2'd1 || lvl_a[5:4] !== 2'd1) begin errors++; $display("FAIL prio_tiles got %h", lvl_a); end
  endtask

  task automatic test_held_reset();
    @(negedge clk);
    btn_a = 4'b1000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if ({hop_a, row_a, col_a} !== 9'h000) begin errors++; $display("FAIL held_reset got %h want 000", {hop_a, row_a, col_a}); end
    btn_a = '0;
    repeat (6) @(negedge clk);
    checks++; if (hop_a !== 1'b0) begin errors++; $display("FAIL held_release got %b want 0", hop_a); end
  endtask

  task automatic test_win();
    do_reset();
    press(1'b1, 4'b0100); ticks(HF, 0);
    press(1'b1, 4'b0100); ticks(HF, 0);
    checks++; if ({row_b, col_b, lives_b} !== {8'h00, 3'd2}) begin errors++; $display("FAIL win_fall got %h", {row_b, col_b, lives_b}); end
    press(1'b1, 4'b1000); ticks(HF, 0);
    press(1'b1, 4'b0001); ticks(HF, 0);
    checks++; if ({ganar_b, row_b, col_b} !== 9'h000) begin errors++; $display("FAIL win_early got %h want 000", {ganar_b, row_b, col_b}); end
    @(negedge clk);
    checks++; if ({ganar_b, lost_b} !== 2'b10) begin errors++; $display("FAIL win_flag got %b want 10", {ganar_b, lost_b}); end
    checks++; if (lvl_b !== 6'b010101) begin errors++; $display("FAIL win_tiles got %b want 010101", lvl_b); end
    press(1'b1, 4'b0100); ticks(HF, 0);
    checks++; if ({ganar_b, hop_b, row_b, col_b, lives_b} !== {2'b10, 8'h00, 3'd2}) begin errors++; $display("FAIL win_frozen got %h", {ganar_b, hop_b, row_b, col_b, lives_b}); end
  endtask

  task automatic test_revert();
    logic [1:0] want;
`ifdef QBERT_REVERT_EN
    want = 2'd0;
`else
    want = 2'd1;
`endif
    do_reset();
    press(1'b0, 4'b0100); ticks(HF, 0);
    checks++; if (lvl_a[3:2] !== 2'd1) begin errors++; $display("FAIL revert_first got %0d want 1", lvl_a[3:2]); end
    press(1'b0, 4'b0010); ticks(HF, 0);
    press(1'b0, 4'b0100); ticks(HF, 0);
    checks++; if (lvl_a[3:2] !== want) begin errors++; $display("FAIL revert_second got %0d want %0d", lvl_a[3:2], want); end
    press(1'b0, 4'b1000);
    ticks(3, 0);
    rst_n = 1'b0;
    #1;
    checks++; if ({hop_a, row_a, col_a, lives_a, lost_a, ganar_a} !== {1'b0, 8'h00, 3'd3, 2'b00}) begin errors++; $display("FAIL midhop_reset got %h", {hop_a, row_a, col_a, lives_a, lost_a, ganar_a}); end
    checks++; if (lvl_a !== '0) begin errors++; $display("FAIL midhop_tiles got %h want 0", lvl_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    model_reset();
  endtask

  task automatic test_random();
    logic [3:0] mask;
    logic [2*NT_A-1:0] exp_lvl;
    int b;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      mask = 4'($urandom_range(1, 15));
      b = first_btn(mask);
      press(1'b0, mask);
      model_move(b);
      ticks(HF, 2);
      repeat (2) @(negedge clk);
      for (int i = 0; i < NT_A; i++) exp_lvl[2*i +: 2] = 2'(m_lvl[i]);
      checks++; if ({row_a, col_a} !== {4'(m_row), 4'(m_col)}) begin errors++; $display("FAIL rnd_pos move %0d got %h want %h", n, {row_a, col_a}, {4'(m_row), 4'(m_col)}); end
      checks++; if (lives_a !== 3'(m_lives)) begin errors++; $display("FAIL rnd_lives move %0d got %0d want %0d", n, lives_a, m_lives); end
      checks++; if (lvl_a !== exp_lvl) begin errors++; $display("FAIL rnd_tiles move %0d got %h want %h", n, lvl_a, exp_lvl); end
      checks++; if ({lost_a, ganar_a, hop_a} !== {m_lost, m_won, 1'b0}) begin errors++; $display("FAIL rnd_flags move %0d got %b want %b", n, {lost_a, ganar_a, hop_a}, {m_lost, m_won, 1'b0}); end
      checks++; if (led_a !== seg_exp(m_lives)) begin errors++; $display("FAIL rnd_led move %0d got %b want %b", n, led_a, seg_exp(m_lives)); end
      if (m_lost || m_won) do_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hop();
    test_fall();
    test_lost();
    test_priority();
    test_held_reset();
    test_win();
    test_revert();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
